alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// One operation is in flight at a time. The operands are registered toward
// the ALU, the result is captured one cycle later, and the response is held
// until the consumer takes it. Ties go to the requester that did not win
// the previous grant.
//
// state | meaning
// IDLE  | ready to grant; reqN_ready follows the arbitration rule
// EXEC  | operands are on alu_*; alu_result is captured at the end of this cycle
// RESP  | rsp_valid held with a stable id and result until rsp_ready
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant0;
    logic   grant1;

    // Arbitration: a lone requester wins; on a tie the one that lost last time wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    // Ready is offered only while idle, so an accept can never overlap a response.
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    // Sequencer: accept, execute for one cycle, then hold the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_op     <= req0_op;
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        rsp_id     <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (grant1) begin
                        alu_op     <= req1_op;
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        rsp_id     <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Winner among pending requesters, -1 if nobody asks.
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Reference model: where the current transaction is (0 free, 1 computing,
    // 2 response outstanding) and what it carries.
    int         m_phase;
    logic       m_last, m_id;
    logic [3:0] m_op;
    logic [W-1:0] m_a, m_b, m_res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_last = 1'b1; m_id = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0;
        end else if (m_phase == 0) begin
            int w;
            w = pick(req0_valid, req1_valid, m_last);
            if (w == 0) begin
                m_op = req0_op; m_a = req0_a; m_b = req0_b; m_id = 1'b0;
            end else if (w == 1) begin
                m_op = req1_op; m_a = req1_a; m_b = req1_b; m_id = 1'b1;
            end
            if (w >= 0) begin
                m_last  = m_id;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_res   = alu_fn(m_op, m_a, m_b);
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int w;
        if (reset) begin
            w = pick(req0_valid, req1_valid, m_last);
            chk("req0_ready", 32'(req0_ready), 32'(m_phase == 0 && w == 0));
            chk("req1_ready", 32'(req1_ready), 32'(m_phase == 0 && w == 1));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (m_phase == 2) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_result", rsp_result, m_res);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   glog[$];
    int   gcyc[$];
    bit   seen;
    logic f0, f1;

    initial begin
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready  = 1;

        // Reset state, and ready follows the grant rule even while held in reset.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_req0_ready_idle", 32'(req0_ready), 32'd0);
        req0_valid = 1;
        #1;
        chk("rst_req0_ready_grant", 32'(req0_ready), 32'd1);
        req0_valid = 0;
        @(negedge clk);
        #2 reset = 1;

        // Single request: 5 + 7.
        step();
        req0_valid = 1; req0_op = 4'b0010; req0_a = 5; req0_b = 7;
        @(negedge clk);
        chk("single_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 0; req0_a = 99;
        @(negedge clk);
        chk("single_exec_valid", 32'(rsp_valid), 32'd0);
        chk("single_alu_a", alu_a, 32'd5);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        chk("single_rsp_result", rsp_result, 32'd12);
        step();

        // Fresh reset, then continuous contention: 0,1,0,1 every 3 cycles.
        @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        #2 reset = 1;
        step();
        req0_valid = 1; req0_op = 4'b0010; req0_a = 1;  req0_b = 1;
        req1_valid = 1; req1_op = 4'b0110; req1_a = 10; req1_b = 3;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("tie_req0_first", 32'(req0_ready), 32'd1);
                chk("tie_req1_wait", 32'(req1_ready), 32'd0);
            end
            if (req0_ready && req1_ready) chk("both_ready", 32'd1, 32'd0);
            if (req0_ready) begin glog.push_back(0); gcyc.push_back(c); end
            if (req1_ready) begin glog.push_back(1); gcyc.push_back(c); end
        end
        step();
        req0_valid = 0; req1_valid = 0;
        chk("contend_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            chk("contend_order", 32'(glog[i]), 32'(i % 2));
            chk("contend_interval", 32'(gcyc[i]), 32'(3 * i));
        end
        repeat (3) step();

        // Backpressure: response held for 5 cycles while req0 waits.
        rsp_ready = 0;
        req1_valid = 1; req1_op = 4'b0010; req1_a = 3; req1_b = 4;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("bp_rsp_arrived", 32'(seen), 32'd1);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'b0001; req0_a = 32'hF0; req0_b = 32'h0F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_result", rsp_result, 32'd7);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
        end
        step();
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_no_accept", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 0;
        repeat (3) step();

        // Operand hold during EXEC, then asynchronous reset mid-operation.
        req1_valid = 1; req1_op = 4'b0010; req1_a = 20; req1_b = 22;
        @(negedge clk);
        chk("hold_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 0; req1_a = 1000; req1_b = 1;
        @(negedge clk);
        chk("hold_alu_a", alu_a, 32'd20);
        chk("hold_alu_b", alu_b, 32'd22);
        #1 reset = 0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        #2 reset = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(rsp_valid), 32'd0);
        end
        step();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("arst_tie_req0", 32'(req0_ready), 32'd1);
        chk("arst_tie_req1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        // Randomized traffic; a pending request is held until it is granted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || f0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 4'($urandom_range(0, 15));
                req0_a = $urandom; req0_b = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                req0_a = $urandom;
            end
            if (!req1_valid || f1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 4'($urandom_range(0, 15));
                req1_a = $urandom; req1_b = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                req1_b = $urandom;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (c == 1500) begin
                #2 reset = 0;
                #4 reset = 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
